sbox_scheduler: RTL and testbench
=================================

# sbox_scheduler

Round-robin arbiter and sequencer for the single shared masked S-box. It accepts two-share bytes from two requesters: the state datapath and the key schedule. It issues one byte per cycle into the S-box, with the Kronecker (zero-detect) shares leading the S-box shares by a fixed offset, and tags each byte so the fixed-latency result returns to its owner with its byte index. It sits between the round datapath / key expansion and the `Sbox` instance in the AES round core.

## Interface
Parameters:
- `SB_LAT`, 4, cycles from `sb_in` to `sb_out` inside the S-box
- `KRON_LEAD`, 2, cycles by which `sb_kron_in` must lead `sb_in`

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `abort` in 1: synchronous flush of all in-flight work
- `st_req_valid` in 1: state requester has a byte
- `st_req_data` in 16: state byte shares, {share1, share0}
- `st_req_ready` out 1: state byte accepted this cycle
- `ks_req_valid` in 1: key-schedule requester has a byte
- `ks_req_data` in 16: key byte shares, {share1, share0}
- `ks_req_ready` out 1: key byte accepted this cycle
- `sb_kron_in` out 16: to `Sbox.shared_kron_in`
- `sb_in` out 16: to `Sbox.shared_SB_in`
- `sb_out` in 16: from `Sbox.SB_out`
- `rsp_data` out 16: S-box result shares
- `st_rsp_valid` out 1: `rsp_data` belongs to the state requester
- `ks_rsp_valid` out 1: `rsp_data` belongs to the key requester
- `rsp_idx` out 4: byte index of the response (state 0..15, key 0..3)
- `busy` out 1: at least one byte in flight
- `prng_en` out 1: S-box randomness in use; the PRNG may advance

## Operation
- Issue rate: at most one grant per cycle. The S-box cannot stall and responses have no backpressure; requesters must sink results.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: round-robin on a 1-bit last-grant pointer; the side not granted last wins.
  - After reset or `abort`, the pointer favours `ks` on the first tie.
- `*_req_ready` is combinational from valid, pointer and `abort`; it is low on both sides while `abort`=1.
- Index counters:
  - State issue counter: 4 bits, increments per state grant, wraps 15→0.
  - Key issue counter: 2 bits, wraps 3→0, zero-extended onto `rsp_idx`.
  - Both clear on reset and on `abort`.
- Issue pipeline:
  - Granted data is registered onto `sb_kron_in`.
  - The same data passes through a `KRON_LEAD`-deep register chain onto `sb_in`.
- Tag pipeline:
  - {valid, owner, idx} shifts alongside the data for `KRON_LEAD+SB_LAT` further stages.
  - The final stage qualifies `sb_out` → `rsp_data`.
- Share hygiene:
  - Shares are never XORed, compared or combined in this block.
  - `sb_kron_in`, `sb_in` and `rsp_data` are driven to 0 in any cycle with no valid tag at that stage.
- `abort`: clears all tag valids, counters and pointer, and zeroes the data registers at the next edge. In-flight results never appear.
- `busy`: OR of all tag-stage valids. `prng_en` = `busy`.

## Timing
- Reset (async, `rst_n`=0): all outputs 0. This includes `*_ready`, since `*_ready` is forced 0 while in reset; pointer favours `ks`.
- Grant at edge k (valid && ready sampled):
  - `sb_kron_in` valid in the cycle after edge k.
  - `sb_in` valid `KRON_LEAD` cycles later.
  - Response valid L = 1+`KRON_LEAD`+`SB_LAT` cycles after the grant cycle (default L = 7).
- Back-to-back grants produce back-to-back responses, in grant order, with no bubbles.
- Exactly one of `st_rsp_valid`/`ks_rsp_valid` is high per response cycle; never both.
- `abort` coinciding with requests: no grant that cycle.
- `abort` coinciding with a response cycle: that response is still presented (it was registered before the edge); everything behind it is dropped.
- Reset mid-operation: identical to `abort`, but asynchronous.

## Structure
- Shared package `aes_ctrl_pkg`:
  - owner enum `OWN_ST`/`OWN_KS`
  - tag struct {valid, owner, idx[3:0]}
  - constants `NB_STATE`=16, `NB_KEY`=4
- One sub-module `sbox_tag_pipe`: parameterised-depth shift register of tag structs with sync clear and async reset, reused for the data delay chain by width parameter.
- Arbiter and counters live in the top module.

## Test plan
- Single state byte 16'hA55A after reset → `sb_kron_in`=16'hA55A one cycle later, `sb_in`=16'hA55A at +3. S-box model returns 16'h1234 → `st_rsp_valid`=1, `rsp_data`=16'h1234, `rsp_idx`=0, exactly 7 cycles after grant.
- Both valid continuously for 8 cycles → grants alternate ks, st, ks, st… Key idx sequence 0,1,2,3; state idx 0,1,2,3. Responses follow in the same order.
- 16 consecutive state bytes with ks idle → 16 grants on consecutive cycles, `rsp_idx` 0..15 then 0 on the 17th. `busy` falls exactly 7 cycles after the last grant.
- `abort` asserted 3 cycles after 5 grants → no responses after the abort edge except any already at the output stage. Counters are 0, the next tie goes to ks, and `busy`=0 one cycle later.
- `rst_n` pulsed low mid-stream → all outputs 0 immediately (asynchronous), no stale response after release.
- Idle cycles between grants → `sb_kron_in`, `sb_in` and `rsp_data` read 0 in every non-valid cycle.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared types for the AES round-core control slice.
// Owner enum, S-box tag struct and byte-count constants.
package aes_ctrl_pkg;

  localparam int NB_STATE = 16;
  localparam int NB_KEY   = 4;
  localparam int ST_IW    = $clog2(NB_STATE);
  localparam int KS_IW    = $clog2(NB_KEY);

  typedef enum logic {
    OWN_ST = 1'b0,
    OWN_KS = 1'b1
  } owner_e;

  typedef struct packed {
    logic       valid;
    owner_e     owner;
    logic [3:0] idx;
  } tag_t;

endpackage

// File: rtl/sbox_tag_pipe.sv
// sbox_tag_pipe: DEPTH-stage shift register, W bits wide, sync clr.
// Ports: clk, rst_n, clr, d in; stg out (all stages, stg[0] newest).
import aes_ctrl_pkg::*;

module sbox_tag_pipe #(
  parameter int W     = $bits(tag_t),
  parameter int DEPTH = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic [W-1:0]              d,
  output logic [DEPTH-1:0][W-1:0]   stg
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= '0;
    end else if (clr) begin
      stg <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

endmodule

// File: rtl/sbox_scheduler.sv
// sbox_scheduler: round-robin st/ks arbiter feeding the shared masked S-box.
// Ports: st/ks req handshakes, sb_kron_in/sb_in/sb_out, tagged rsp, busy.
import aes_ctrl_pkg::*;

module sbox_scheduler #(
  parameter int SB_LAT    = 4,
  parameter int KRON_LEAD = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic        st_req_valid,
  input  logic [15:0] st_req_data,
  output logic        st_req_ready,
  input  logic        ks_req_valid,
  input  logic [15:0] ks_req_data,
  output logic        ks_req_ready,
  output logic [15:0] sb_kron_in,
  output logic [15:0] sb_in,
  input  logic [15:0] sb_out,
  output logic [15:0] rsp_data,
  output logic        st_rsp_valid,
  output logic        ks_rsp_valid,
  output logic [3:0]  rsp_idx,
  output logic        busy,
  output logic        prng_en
);

  localparam int TAG_D = 1 + KRON_LEAD + SB_LAT;
  localparam int DAT_D = 1 + KRON_LEAD;
  localparam int TW    = $bits(tag_t);

  logic             last_ks;
  logic [ST_IW-1:0] st_cnt;
  logic [KS_IW-1:0] ks_cnt;
  logic             gnt_st;
  logic             gnt_ks;
  tag_t             tag_in;
  logic [15:0]      dat_in;
  tag_t             tail;

  logic [TAG_D-1:0][TW-1:0] tag_stg;
  logic [DAT_D-1:0][15:0]   dat_stg;

  // rst_n gates ready so nothing is accepted while reset is held.
  assign gnt_st = rst_n & ~abort & st_req_valid
                & (~ks_req_valid | last_ks);
  assign gnt_ks = rst_n & ~abort & ks_req_valid
                & (~st_req_valid | ~last_ks);

  assign st_req_ready = gnt_st;
  assign ks_req_ready = gnt_ks;

  // Idle cycles push zero data so the S-box
  // never sees stale shares.
  always_comb begin
    tag_in = '0;
    dat_in = '0;
    unique case (1'b1)
      gnt_st: begin
        tag_in.valid = 1'b1;
        tag_in.owner = OWN_ST;
        tag_in.idx   = st_cnt;
        dat_in       = st_req_data;
      end
      gnt_ks: begin
        tag_in.valid = 1'b1;
        tag_in.owner = OWN_KS;
        tag_in.idx   = {{(4-KS_IW){1'b0}}, ks_cnt};
        dat_in       = ks_req_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ks <= 1'b0;
      st_cnt  <= '0;
      ks_cnt  <= '0;
    end else if (abort) begin
      last_ks <= 1'b0;
      st_cnt  <= '0;
      ks_cnt  <= '0;
    end else begin
      if (gnt_st) begin
        st_cnt  <= st_cnt + 1'b1;
        last_ks <= 1'b0;
      end
      if (gnt_ks) begin
        ks_cnt  <= ks_cnt + 1'b1;
        last_ks <= 1'b1;
      end
    end
  end

  sbox_tag_pipe #(
    .W     (TW),
    .DEPTH (TAG_D)
  ) u_tag (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort),
    .d     (tag_in),
    .stg   (tag_stg)
  );

  sbox_tag_pipe #(
    .W     (16),
    .DEPTH (DAT_D)
  ) u_dat (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort),
    .d     (dat_in),
    .stg   (dat_stg)
  );

  // Middle data stages only feed the delay chain.
  logic unused_dat;
  assign unused_dat = ^dat_stg;

  assign sb_kron_in = dat_stg[0];
  assign sb_in      = dat_stg[KRON_LEAD];

  assign tail = tag_t'(tag_stg[TAG_D-1]);

  assign rsp_data     = tail.valid ? sb_out : 16'h0;
  assign st_rsp_valid = tail.valid & (tail.owner == OWN_ST);
  assign ks_rsp_valid = tail.valid & (tail.owner == OWN_KS);
  assign rsp_idx      = tail.idx;

  always_comb begin
    tag_t t;
    busy = 1'b0;
    for (int i = 0; i < TAG_D; i++) begin
      t    = tag_t'(tag_stg[i]);
      busy = busy | t.valid;
    end
  end

  assign prng_en = busy;

endmodule

// File: tb/tb_sbox_scheduler.sv
// tb_sbox_scheduler: directed stimulus with a response scoreboard.
// Driver predicts grants and pushes expected responses; monitor pops.
module tb_sbox_scheduler;
  import aes_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        abort = 1'b0;
  logic        st_req_valid = 1'b0;
  logic [15:0] st_req_data = '0;
  logic        st_req_ready;
  logic        ks_req_valid = 1'b0;
  logic [15:0] ks_req_data = '0;
  logic        ks_req_ready;
  logic [15:0] sb_kron_in;
  logic [15:0] sb_in;
  logic [15:0] sb_out;
  logic [15:0] rsp_data;
  logic        st_rsp_valid;
  logic        ks_rsp_valid;
  logic [3:0]  rsp_idx;
  logic        busy;
  logic        prng_en;

  sbox_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .abort        (abort),
    .st_req_valid (st_req_valid),
    .st_req_data  (st_req_data),
    .st_req_ready (st_req_ready),
    .ks_req_valid (ks_req_valid),
    .ks_req_data  (ks_req_data),
    .ks_req_ready (ks_req_ready),
    .sb_kron_in   (sb_kron_in),
    .sb_in        (sb_in),
    .sb_out       (sb_out),
    .rsp_data     (rsp_data),
    .st_rsp_valid (st_rsp_valid),
    .ks_rsp_valid (ks_rsp_valid),
    .rsp_idx      (rsp_idx),
    .busy         (busy),
    .prng_en      (prng_en)
  );

  typedef struct {
    logic        ks;
    logic [3:0]  idx;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] exp_kron [0:1023];
  logic [15:0] exp_sbin [0:1023];
  logic [15:0] sbp [0:3];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic        m_last_ks = 1'b0;
  logic [3:0]  m_st = '0;
  logic [1:0]  m_ks = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // S-box model: 4-cycle latency, byte swap, one special vector.
  function automatic logic [15:0] sbf(input logic [15:0] x);
    if (x == 16'hA55A) return 16'h1234;
    return {x[7:0], x[15:8]};
  endfunction

  always @(posedge clk) begin
    sbp[0] <= sb_in;
    for (int i = 1; i < 4; i++) sbp[i] <= sbp[i-1];
  end

  assign sb_out = sbf(sbp[3]);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int ci(input int c);
    return (c < 1024) ? c : 1023;
  endfunction

  always @(negedge clk) begin : mon
    logic bexp;
    exp_t e;
    bexp = 1'b0;
    foreach (sbq[i])
      if (cyc >= sbq[i].cyc - 6 && cyc <= sbq[i].cyc) bexp = 1'b1;
    chk("busy", 32'(busy), 32'(bexp));
    chk("prng_en", 32'(prng_en), 32'(bexp));
    chk("sb_kron_in", 32'(sb_kron_in), 32'(exp_kron[ci(cyc)]));
    chk("sb_in", 32'(sb_in), 32'(exp_sbin[ci(cyc)]));
    chk("both_rsp_valid", 32'(st_rsp_valid & ks_rsp_valid), 0);
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL rsp_missing: got none want idx %0d at cyc %0d",
               e.idx, e.cyc);
    end
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      chk("st_rsp_valid", 32'(st_rsp_valid), 32'(!e.ks));
      chk("ks_rsp_valid", 32'(ks_rsp_valid), 32'(e.ks));
      chk("rsp_idx", 32'(rsp_idx), 32'(e.idx));
      chk("rsp_data", 32'(rsp_data), 32'(e.data));
    end else begin
      chk("st_rsp_valid_idle", 32'(st_rsp_valid), 0);
      chk("ks_rsp_valid_idle", 32'(ks_rsp_valid), 0);
      chk("rsp_data_idle", 32'(rsp_data), 0);
      chk("rsp_idx_idle", 32'(rsp_idx), 0);
    end
  end

  task automatic flush_after(input int c);
    for (int i = sbq.size() - 1; i >= 0; i--)
      if (sbq[i].cyc > c) sbq.delete(i);
    for (int k = c + 1; k < c + 5; k++) begin
      exp_kron[ci(k)] = '0;
      exp_sbin[ci(k)] = '0;
    end
    m_st = '0;
    m_ks = '0;
    m_last_ks = 1'b0;
  endtask

  task automatic drive(input logic sv, input logic [15:0] sd,
                       input logic kv, input logic [15:0] kd,
                       input logic ab,
                       output logic gs, output logic gk);
    exp_t e;
    @(posedge clk);
    #1;
    st_req_valid = sv;
    st_req_data  = sd;
    ks_req_valid = kv;
    ks_req_data  = kd;
    abort        = ab;
    #1;
    gs = 1'b0;
    gk = 1'b0;
    if (!ab) begin
      if (sv && kv) begin
        if (m_last_ks) gs = 1'b1;
        else gk = 1'b1;
      end else if (sv) gs = 1'b1;
      else if (kv) gk = 1'b1;
    end
    chk("st_req_ready", 32'(st_req_ready), 32'(gs));
    chk("ks_req_ready", 32'(ks_req_ready), 32'(gk));
    if (gs || gk) begin
      e.ks   = gk;
      e.idx  = gs ? m_st : {2'b00, m_ks};
      e.data = sbf(gs ? sd : kd);
      e.cyc  = cyc + 7;
      sbq.push_back(e);
      exp_kron[ci(cyc + 1)] = gs ? sd : kd;
      exp_sbin[ci(cyc + 3)] = gs ? sd : kd;
      if (gs) begin m_st++; m_last_ks = 1'b0; end
      else begin m_ks++; m_last_ks = 1'b1; end
    end
    if (ab) flush_after(cyc);
  endtask

  task automatic idle(input int n);
    logic gs, gk;
    for (int i = 0; i < n; i++) drive(0, '0, 0, '0, 0, gs, gk);
  endtask

  task automatic do_abort(input logic sv, input logic kv);
    logic gs, gk;
    drive(sv, 16'h7E81, kv, 16'h3C99, 1, gs, gk);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    abort = 1'b0;
    st_req_valid = 1'b1;
    ks_req_valid = 1'b1;
    #1;
    chk("rst_st_ready", 32'(st_req_ready), 0);
    chk("rst_ks_ready", 32'(ks_req_ready), 0);
    chk("rst_sb_kron_in", 32'(sb_kron_in), 0);
    chk("rst_sb_in", 32'(sb_in), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_st_rsp_valid", 32'(st_rsp_valid), 0);
    chk("rst_ks_rsp_valid", 32'(ks_rsp_valid), 0);
    chk("rst_rsp_idx", 32'(rsp_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_prng_en", 32'(prng_en), 0);
    sbq.delete();
    for (int k = cyc; k < cyc + 5; k++) begin
      exp_kron[ci(k)] = '0;
      exp_sbin[ci(k)] = '0;
    end
    m_st = '0;
    m_ks = '0;
    m_last_ks = 1'b0;
    @(posedge clk);
    #1;
    st_req_valid = 1'b0;
    ks_req_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  logic [15:0] stv [8] = '{16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978,
                           16'h8796, 16'hA5B4, 16'hC3D2, 16'hE1F0};
  logic [15:0] ksv [8] = '{16'h1357, 16'h9BDF, 16'h2468, 16'hACE0,
                           16'h1122, 16'h3344, 16'h5566, 16'h7788};

  initial begin
    logic gs, gk;
    int si, ki;
    for (int i = 0; i < 1024; i++) begin
      exp_kron[i] = '0;
      exp_sbin[i] = '0;
    end
    #2;
    rst_n = 1'b0;
    st_req_valid = 1'b1;
    ks_req_valid = 1'b1;
    #1;
    chk("init_st_ready", 32'(st_req_ready), 0);
    chk("init_ks_ready", 32'(ks_req_ready), 0);
    chk("init_busy", 32'(busy), 0);
    chk("init_rsp_data", 32'(rsp_data), 0);
    chk("init_sb_kron_in", 32'(sb_kron_in), 0);
    repeat (2) @(posedge clk);
    #1;
    st_req_valid = 1'b0;
    ks_req_valid = 1'b0;
    rst_n = 1'b1;

    // single state byte, latency and share path
    drive(1, 16'hA55A, 0, '0, 0, gs, gk);
    idle(9);

    // both valid: ks wins first tie after abort, then alternate
    do_abort(0, 0);
    si = 0;
    ki = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1, stv[si], 1, ksv[ki], 0, gs, gk);
      if (gs) si++;
      if (gk) ki++;
    end
    idle(9);

    // 17 back-to-back state bytes: idx wraps 15 -> 0
    do_abort(0, 0);
    for (int i = 0; i < 17; i++)
      drive(1, {8'(8'h10 + i), 8'(8'hC0 + i)}, 0, '0, 0, gs, gk);
    idle(9);

    // abort 3 cycles after 5 grants, with requests pending
    for (int i = 0; i < 5; i++)
      drive(1, {8'(8'h40 + i), 8'h09}, 0, '0, 0, gs, gk);
    idle(2);
    do_abort(1, 1);
    drive(1, 16'h5A01, 1, 16'h6B02, 0, gs, gk);
    drive(1, 16'h5A01, 0, '0, 0, gs, gk);
    idle(9);

    // idle gaps between grants
    drive(1, 16'hBEEF, 0, '0, 0, gs, gk);
    idle(2);
    drive(0, '0, 1, 16'hCAFE, 0, gs, gk);
    idle(3);
    drive(1, 16'hF00D, 0, '0, 0, gs, gk);
    idle(9);

    // reset mid-stream
    for (int i = 0; i < 4; i++)
      drive(1, {8'(8'h70 + i), 8'h33}, 1, {8'h44, 8'(8'h80 + i)},
            0, gs, gk);
    reset_pulse();
    idle(10);
    drive(0, '0, 1, 16'h0102, 0, gs, gk);
    idle(9);

    if (sbq.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL rsp_drain: got %0d left want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
